// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer and its hand storage.
package card_dealer_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned HAND_INIT   = 7;
  localparam int unsigned MAX_HAND    = 32;
  localparam int unsigned PW          = 2;
  localparam int unsigned HW          = 5;
  localparam int unsigned CW          = HW + 1;
  localparam int unsigned NUM_W       = 3;
  localparam int unsigned DRAW_MAX    = 4;
  localparam int unsigned DEAL_TOTAL  = NUM_PLAYERS * HAND_INIT;
  localparam int unsigned RW          = $clog2(DEAL_TOTAL + 1);

  localparam logic [NUM_W-1:0] DRAW_ONE = 3'b001;

  // Card colors
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  // Special card values (0..9 are number cards)
  localparam logic [3:0] SKIP  = 4'd10;
  localparam logic [3:0] REV   = 4'd11;
  localparam logic [3:0] DRAW2 = 4'd12;
  localparam logic [3:0] WILD  = 4'd13;
  localparam logic [3:0] WILD4 = 4'd14;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHUF_REQ,
    S_SHUF_WAIT,
    S_REQ,
    S_WAIT,
    S_REMOVE
  } state_t;

endpackage

// File: rtl/card_dealer_if.sv
// Handshake between the dealer and the shuffled-deck block.
interface card_dealer_if;
  import card_dealer_pkg::*;

  logic             deck_start;
  logic [NUM_W-1:0] deck_draw;
  logic             deck_done;
  logic             deck_drawn;
  card_t            deck_card;

  modport master (output deck_start, deck_draw, input deck_done, deck_drawn, deck_card);
  modport slave  (input deck_start, deck_draw, output deck_done, deck_drawn, deck_card);
endinterface

// File: rtl/card_dealer_hand_store.sv
// One player's hand: MAX_HAND card slots plus a fill count.
module hand_store
  import card_dealer_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  card_t         i_push_card,
  input  logic          i_remove,
  input  logic [HW-1:0] i_remove_idx,
  input  logic [HW-1:0] i_rd_idx,
  output card_t         o_rd_card_c,
  output logic [CW-1:0] o_count,
  output logic          o_full_c
);

  card_t         slots [MAX_HAND];
  logic [HW-1:0] last_c;

  assign last_c      = HW'(o_count - CW'(1));
  assign o_full_c    = (o_count == CW'(MAX_HAND));
  assign o_rd_card_c = (CW'(i_rd_idx) < o_count) ? slots[i_rd_idx] : '0;

  // Append on push (dropped when full); remove fills the hole with the last card.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(MAX_HAND); i++) slots[i] <= '0;
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_push && !o_full_c) begin
      slots[o_count[HW-1:0]] <= i_push_card;
      o_count                <= o_count + CW'(1);
    end else if (i_remove && (CW'(i_remove_idx) < o_count)) begin
      slots[i_remove_idx] <= slots[last_c];
      slots[last_c]       <= '0;
      o_count             <= o_count - CW'(1);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: shuffles via the deck block, deals round-robin, serves draw/play commands.
module card_dealer
  import card_dealer_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_draw_req,
  input  logic [NUM_W-1:0]          i_draw_num,
  input  logic                      i_play_req,
  input  logic [PW-1:0]             i_player,
  input  logic [HW-1:0]             i_play_idx,
  input  logic [PW-1:0]             i_rd_player,
  input  logic [HW-1:0]             i_rd_idx,
  output card_t                     o_rd_card,
  output logic [NUM_PLAYERS*CW-1:0] o_count,
  output logic                      o_busy,
  output logic                      o_deal_done,
  output logic                      o_err,
  card_dealer_if.master             deck
);

  state_t        state;
  logic [PW-1:0] cur_player;
  logic [PW-1:0] rm_player;
  logic [HW-1:0] rm_idx;
  logic [RW-1:0] remaining;
  logic          deal_mode;
  logic          shuf_wait_cnt;

  logic [CW-1:0] count   [NUM_PLAYERS];
  card_t         rd_card [NUM_PLAYERS];
  logic          full    [NUM_PLAYERS];

  logic clr_c, capture_c, draw_ok_c, rm_bad_c;

  assign clr_c     = (state == S_SHUF_REQ);
  assign capture_c = (state == S_REQ) && deck.deck_drawn;
  assign draw_ok_c = (i_draw_num != '0) && (i_draw_num <= NUM_W'(DRAW_MAX));
  assign rm_bad_c  = (CW'(rm_idx) >= count[rm_player]);
  assign o_rd_card = rd_card[i_rd_player];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_hand
    hand_store u_hand (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clr        (clr_c),
      .i_push       (capture_c && (cur_player == PW'(p))),
      .i_push_card  (deck.deck_card),
      .i_remove     ((state == S_REMOVE) && (rm_player == PW'(p))),
      .i_remove_idx (rm_idx),
      .i_rd_idx     (i_rd_idx),
      .o_rd_card_c  (rd_card[p]),
      .o_count      (count[p]),
      .o_full_c     (full[p])
    );
    assign o_count[p*CW +: CW] = count[p];
  end

  // Dealer FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      cur_player      <= '0;
      rm_player       <= '0;
      rm_idx          <= '0;
      remaining       <= '0;
      deal_mode       <= 1'b0;
      shuf_wait_cnt   <= 1'b0;
      o_busy          <= 1'b0;
      o_deal_done     <= 1'b0;
      o_err           <= 1'b0;
      deck.deck_start <= 1'b0;
      deck.deck_draw  <= '0;
    end else begin
      o_deal_done     <= 1'b0;
      o_err           <= 1'b0;
      deck.deck_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state           <= S_SHUF_REQ;
            o_busy          <= 1'b1;
            deck.deck_start <= 1'b1;
          end else if (i_draw_req) begin
            if (draw_ok_c) begin
              cur_player     <= i_player;
              remaining      <= RW'(i_draw_num);
              deal_mode      <= 1'b0;
              state          <= S_REQ;
              o_busy         <= 1'b1;
              deck.deck_draw <= DRAW_ONE;
            end else begin
              o_err <= 1'b1;
            end
          end else if (i_play_req) begin
            rm_player <= i_player;
            rm_idx    <= i_play_idx;
            state     <= S_REMOVE;
            o_busy    <= 1'b1;
          end
        end
        S_SHUF_REQ: begin
          deal_mode     <= 1'b1;
          cur_player    <= '0;
          remaining     <= RW'(DEAL_TOTAL);
          shuf_wait_cnt <= 1'b0;
          state         <= S_SHUF_WAIT;
        end
        S_SHUF_WAIT: begin
          shuf_wait_cnt <= 1'b1;
          if (shuf_wait_cnt && deck.deck_done) begin
            state          <= S_REQ;
            deck.deck_draw <= DRAW_ONE;
          end
        end
        S_REQ: begin
          if (deck.deck_drawn) begin
            o_err          <= full[cur_player];
            deck.deck_draw <= '0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (deck.deck_done) begin
            remaining <= remaining - RW'(1);
            if (deal_mode)
              cur_player <= (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + PW'(1);
            if (remaining == RW'(1)) begin
              state       <= S_IDLE;
              o_busy      <= 1'b0;
              o_deal_done <= deal_mode;
              deal_mode   <= 1'b0;
            end else begin
              state          <= S_REQ;
              deck.deck_draw <= DRAW_ONE;
            end
          end
        end
        S_REMOVE: begin
          o_err  <= rm_bad_c;
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          o_busy         <= 1'b0;
          deck.deck_draw <= '0;
        end
      endcase
    end
  end

endmodule
